regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised successor to the single-cycle register file, intended for the pipelined core.
- Provides N combinational read ports, one posedge write port and a hard-wired zero register.
- Adds a post-reset hardware clear sequencer, which gives deterministic zero contents instead of X.
- Adds a per-register pending scoreboard for hazard detection between issue and writeback.

Parameters:
- XLEN, 32: data width in bits.
- NREGS, 32: number of architectural registers, including x0. Must be a power of 2 and at least 4.
- NRPORTS, 2: number of read ports, 1..4.
- AW, $clog2(NREGS): address width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- wr_en  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  XLEN  write data (signed).
- raddr  in  NRPORTS*AW  read addresses; port p occupies bits [p*AW +: AW].
- rdata  out  NRPORTS*XLEN  read data; port p occupies bits [p*XLEN +: XLEN].
- rpend  out  NRPORTS  scoreboard pending bit for each read address.
- iss_en  in  1  issue: mark iss_addr pending.
- iss_addr  in  AW  destination register of the issuing instruction.
- init_busy  out  1  clear sequence in progress.

Behaviour:
- FSM states: CLEAR, READY.
- While reset=1:
  - state<=CLEAR, clr_ptr<=1.
  - All pending bits <=0.
  - init_busy=1.
- CLEAR:
  - Each cycle, regs[clr_ptr]<=0 and clr_ptr<=clr_ptr+1.
  - When clr_ptr==NREGS-1, write that entry, then go to READY.
  - init_busy drops exactly NREGS-1 cycles after reset deasserts (31 for defaults).
- In CLEAR:
  - wr_en and iss_en are ignored.
  - All rdata=0 and all rpend=0.
- Reset asserted mid-CLEAR restarts the sequence from clr_ptr=1.
- READY, write:
  - If wr_en && waddr!=0, regs[waddr]<=wdata at posedge.
  - Writes to x0 are dropped.
- READY, read:
  - Purely combinational, zero latency.
  - raddr==0 returns 0.
  - Otherwise returns regs[raddr], unless the bypass rule applies (see Optional Feature).
- Scoreboard (READY only):
  - iss_en && iss_addr!=0 sets pend[iss_addr].
  - wr_en && waddr!=0 clears pend[waddr].
  - Same-cycle set and clear of the same address: set wins (a new producer supersedes the old one).
  - Set and clear of different addresses both take effect.
  - pend[0] is constant 0.
  - rpend[p] = pend[raddr[p]] as currently registered.
- Reset values: init_busy=1, rdata=0, rpend=0. Register contents are undefined until CLEAR completes.
- Multiple read ports addressing the same register all return identical data.

Optional Feature:
- Macro: REGFILE_WR_BYPASS_EN.
- Defined (write-first): in READY, when wr_en && waddr!=0 && raddr[p]==waddr, rdata[p]=wdata in the same cycle. rpend[p] also reads 0 for that port unless iss_en targets the same address.
- Undefined (read-old): rdata returns the pre-write contents; the new value is visible from the next cycle. rpend shows the registered value.
- The core's hazard unit depends on this macro: the forward path from WB to ID is omitted when it is defined.

Test Plan:
- Reset 1 cycle, release, hold all reads at addr 5 → init_busy high for exactly 31 cycles, rdata=0 throughout. After init_busy falls, rdata(5)=0 (not X).
- READY: write x7=0xDEADBEEF, next cycle read raddr0=7, raddr1=7 → both ports 0xDEADBEEF. Write x0=0x1234 → read x0 returns 0.
- Same cycle: wr x9=0x55 with raddr0=9 → rdata0=0x55 with REGFILE_WR_BYPASS_EN, old value (0) without it. Next cycle 0x55 in both builds.
- iss_en addr 12 → rpend=1 for raddr=12 next cycle. wr x12 → rpend clears next cycle. Same-cycle iss_en 12 + wr x12 → pend stays 1.
- Reset asserted at cycle 10 of CLEAR after x3=0x77 was written pre-reset → sequence restarts; init_busy lasts 31 more cycles. Final x3=0, all pending bits 0.
- wr_en/iss_en pulses during CLEAR (addr 4, data 0xFF) → after READY, x4=0 and pend[4]=0.

Source files
------------

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with post-reset clear sequencer and pending scoreboard
// Optional write-first read bypass: define REGFILE_WR_BYPASS_EN.
module regfile_mp #(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int NRPORTS = 2,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [AW-1:0]           waddr,
    input  logic [XLEN-1:0]         wdata,
    input  logic [NRPORTS*AW-1:0]   raddr,
    output logic [NRPORTS*XLEN-1:0] rdata,
    output logic [NRPORTS-1:0]      rpend,
    input  logic                    iss_en,
    input  logic [AW-1:0]           iss_addr,
    output logic                    init_busy
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [AW-1:0]   clr_ptr_q, clr_ptr_d;
    logic [NREGS-1:0] pend_q, pend_d;
    logic [XLEN-1:0] regs_q [NREGS];

    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            ready;

    assign ready     = !reset && (state_q == ST_READY);
    assign init_busy = !ready;

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        pend_d    = pend_q;
        rf_we     = 1'b0;
        rf_waddr  = waddr;
        rf_wdata  = wdata;
        if (state_q == ST_CLEAR) begin
            // x0 is never stored, so the sweep starts at 1 and ends at the top entry
            rf_we     = 1'b1;
            rf_waddr  = clr_ptr_q;
            rf_wdata  = '0;
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == AW'(NREGS - 1))
                state_d = ST_READY;
        end else begin
            if (wr_en && waddr != '0) begin
                rf_we          = 1'b1;
                pend_d[waddr]  = 1'b0;
            end
            // issue applied after writeback so a new producer wins over the old one
            if (iss_en && iss_addr != '0)
                pend_d[iss_addr] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= AW'(1);
            pend_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            pend_q    <= pend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && rf_we)
            regs_q[rf_waddr] <= rf_wdata;
    end

    always_comb begin
        rdata = '0;
        rpend = '0;
        for (int p = 0; p < NRPORTS; p++) begin
            if (ready && raddr[p*AW +: AW] != '0) begin
                rdata[p*XLEN +: XLEN] = regs_q[raddr[p*AW +: AW]];
                rpend[p]              = pend_q[raddr[p*AW +: AW]];
`ifdef REGFILE_WR_BYPASS_EN
                if (wr_en && waddr == raddr[p*AW +: AW]) begin
                    rdata[p*XLEN +: XLEN] = wdata;
                    rpend[p]              = iss_en && (iss_addr == raddr[p*AW +: AW]);
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp (directed vectors)
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int AW   = 5;

`ifdef REGFILE_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            wr_en;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
    logic [2*AW-1:0] raddr;
    logic [2*XLEN-1:0] rdata;
    logic [1:0]      rpend;
    logic            iss_en;
    logic [AW-1:0]   iss_addr;
    logic            init_busy;

    regfile_mp dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .rpend(rpend), .iss_en(iss_en),
        .iss_addr(iss_addr), .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] rd;
        logic [1:0]  rp;
        logic        busy;
    } exp_t;

    exp_t exp_q[$];
    logic chk_valid = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    always @(negedge clk) begin
        if (chk_valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL underflow: DUT output sampled with no expected entry queued");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (rdata !== e.rd || rpend !== e.rp || init_busy !== e.busy) begin
                    n_bad++;
                    $display("FAIL %s: got rdata=%h rpend=%b busy=%b, want rdata=%h rpend=%b busy=%b",
                             e.name, rdata, rpend, init_busy, e.rd, e.rp, e.busy);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] r0, input logic [31:0] r1,
                         input logic p0, input logic p1, input logic b);
        exp_t e;
        e.name = nm; e.rd = {r1, r0}; e.rp = {p1, p0}; e.busy = b;
        exp_q.push_back(e);
        chk_valid = 1'b1;
        @(negedge clk);
        #1;
        chk_valid = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        raddr = {a1, a0};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; wr_en = 1'b0; waddr = '0; wdata = '0;
        iss_en = 1'b0; iss_addr = '0; rd(5, 5);
        step();
        check("reset_state", 0, 0, 0, 0, 1);
        step();
        reset = 1'b0;
        // clear sequence, with ignored write/issue pulses aimed at x4
        waddr = 4; wdata = 32'hFF; iss_addr = 4;
        for (int i = 0; i < 31; i++) begin
            wr_en  = (i < 30);
            iss_en = (i < 30);
            check($sformatf("clear_busy_%0d", i), 0, 0, 0, 0, 1);
            step();
        end
        rd(4, 5);
        check("ready_after_clear", 0, 0, 0, 0, 0);

        step(); wr_en = 1; waddr = 7; wdata = 32'hDEADBEEF; rd(0, 0);
        check("wr_x7_read_x0", 0, 0, 0, 0, 0);
        step(); wr_en = 0; rd(7, 7);
        check("read_x7_both", 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
        step(); wr_en = 1; waddr = 0; wdata = 32'h1234; rd(0, 7);
        check("wr_x0_same", 0, 32'hDEADBEEF, 0, 0, 0);
        step(); wr_en = 0; rd(0, 7);
        check("wr_x0_dropped", 0, 32'hDEADBEEF, 0, 0, 0);

        step(); wr_en = 1; waddr = 9; wdata = 32'h55; rd(9, 7);
        check("bypass_x9", BYP ? 32'h55 : 32'h0, 32'hDEADBEEF, 0, 0, 0);
        step(); wr_en = 0;
        check("x9_next", 32'h55, 32'hDEADBEEF, 0, 0, 0);

        step(); iss_en = 1; iss_addr = 12; rd(12, 13);
        check("iss12_same", 0, 0, 0, 0, 0);
        step(); iss_en = 0;
        check("iss12_pend", 0, 0, 1, 0, 0);
        step(); wr_en = 1; waddr = 12; wdata = 32'hAB;
        check("wb12_same", BYP ? 32'hAB : 32'h0, 0, !BYP, 0, 0);
        step(); wr_en = 0;
        check("wb12_cleared", 32'hAB, 0, 0, 0, 0);
        step(); wr_en = 1; waddr = 12; wdata = 32'hCD; iss_en = 1; iss_addr = 12;
        check("iss_wb12_same", BYP ? 32'hCD : 32'hAB, 0, BYP, 0, 0);
        step(); wr_en = 0; iss_en = 0;
        check("iss_wins", 32'hCD, 0, 1, 0, 0);
        step(); wr_en = 1; waddr = 12; wdata = 32'h11; iss_en = 1; iss_addr = 13;
        check("diff_addr_same", BYP ? 32'h11 : 32'hCD, 0, !BYP, 0, 0);
        step(); wr_en = 0; iss_en = 0;
        check("diff_addr_next", 32'h11, 0, 0, 1, 0);

        step(); wr_en = 1; waddr = 3; wdata = 32'h77;
        step(); wr_en = 0; rd(3, 13);
        check("x3_written", 32'h77, 0, 0, 1, 0);
        step(); reset = 1;
        check("reset_again", 0, 0, 0, 0, 1);
        step(); reset = 0;
        for (int i = 0; i < 10; i++) step();
        reset = 1;
        step(); reset = 0;
        for (int i = 0; i < 31; i++) begin
            check($sformatf("restart_busy_%0d", i), 0, 0, 0, 0, 1);
            step();
        end
        check("restart_done", 0, 0, 0, 0, 0);

        step();
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
